pipeline_stage_chain: RTL and testbench

- Parametrised replacement for the hand-instantiated IF/ID, ID/EX, EX/MEM and MEM/WB latch set in the mips core.
- Holds NUM_STAGES pipeline registers of DATA_W bits, each with a valid bit.
- Supports per-stage stall with backward hold propagation, automatic bubble insertion below a stalled stage, and per-stage flush.
- Keeps saturating retire and stall-cycle counters for the debug path.

---
 rtl/pipeline_stage_chain.sv | 116 +++++++++++
 tb/tb_pipeline_stage_chain.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_chain.sv
// Parametrised pipeline latch chain: NUM_STAGES registers with valid bits,
// per-stage stall with upstream hold propagation, bubble insertion below a
// stalled stage, per-stage flush, and saturating retire/stall counters.
module pipeline_stage_chain #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_W     = 129,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_valid,
  input  logic [NUM_STAGES-1:0]        i_stall,
  input  logic [NUM_STAGES-1:0]        i_flush,
  input  logic                         i_global_stall,
  input  logic                         i_clr_counts,
  output logic [NUM_STAGES*DATA_W-1:0] o_data,
  output logic [NUM_STAGES-1:0]        o_valid,
  output logic                         o_ready,
  output logic                         o_retired,
  output logic [CNT_W-1:0]             o_retire_count,
  output logic [CNT_W-1:0]             o_stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_STAGES-1:0][DATA_W-1:0] data_q, data_d, src_data;
  logic [NUM_STAGES-1:0]             vld_q, vld_d, src_vld;
  logic [NUM_STAGES-1:0]             hold, up_hold;
  logic [CNT_W-1:0]                  ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]                  stl_cnt_q, stl_cnt_d;
  logic                              retired;

  // Hold vector: a stall anywhere freezes that stage and everything upstream.
  always_comb begin
    hold[NUM_STAGES-1] = i_global_stall | i_stall[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 0; k--)
      hold[k] = hold[k+1] | i_stall[k];
  end

  // Source of each stage when it advances, and whether its feeder is held
  // (held feeder means a bubble goes in instead of duplicating the entry).
  always_comb begin
    src_data[0] = i_data;
    src_vld[0]  = i_valid;
    up_hold[0]  = 1'b0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      src_data[k] = data_q[k-1];
      src_vld[k]  = vld_q[k-1];
      up_hold[k]  = hold[k-1];
    end
  end

  // Per-stage next state: flush, then hold, then bubble, then advance.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (i_flush[k]) begin
        data_d[k] = '0;
        vld_d[k]  = 1'b0;
      end else if (hold[k]) begin
        data_d[k] = data_q[k];
        vld_d[k]  = vld_q[k];
      end else if (up_hold[k]) begin
        data_d[k] = '0;
        vld_d[k]  = 1'b0;
      end else begin
        data_d[k] = src_data[k];
        vld_d[k]  = src_vld[k];
      end
    end
  end

  // A final-stage entry retires only if it actually leaves and is not flushed.
  assign retired = vld_q[NUM_STAGES-1] & ~hold[NUM_STAGES-1] & ~i_flush[NUM_STAGES-1];

  // Debug counters: clear beats global hold, which beats saturating increment.
  always_comb begin
    ret_cnt_d = ret_cnt_q;
    stl_cnt_d = stl_cnt_q;
    if (i_clr_counts) begin
      ret_cnt_d = '0;
      stl_cnt_d = '0;
    end else if (!i_global_stall) begin
      if (retired && ret_cnt_q != CNT_MAX)
        ret_cnt_d = ret_cnt_q + CNT_ONE;
      if ((|i_stall) && stl_cnt_q != CNT_MAX)
        stl_cnt_d = stl_cnt_q + CNT_ONE;
    end
  end

  // All state registers; async reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      vld_q     <= '0;
      ret_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      vld_q     <= vld_d;
      ret_cnt_q <= ret_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign o_data         = data_q;
  assign o_valid        = vld_q;
  assign o_ready        = ~hold[0];
  assign o_retired      = retired;
  assign o_retire_count = ret_cnt_q;
  assign o_stall_count  = stl_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Scoreboard bench for pipeline_stage_chain: stimulus pushes expected
// observations from a stage-array reference model; a monitor checks at negedge.
module tb_pipeline_stage_chain;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int C    = 4;
  localparam int MAXC = (1 << C) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     i_data = '0;
  logic             i_valid = 1'b0;
  logic [N-1:0]     i_stall = '0;
  logic [N-1:0]     i_flush = '0;
  logic             i_global_stall = 1'b0;
  logic             i_clr_counts = 1'b0;
  logic [N*W-1:0]   o_data;
  logic [N-1:0]     o_valid;
  logic             o_ready;
  logic             o_retired;
  logic [C-1:0]     o_retire_count;
  logic [C-1:0]     o_stall_count;

  pipeline_stage_chain #(.NUM_STAGES(N), .DATA_W(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_stall(i_stall), .i_flush(i_flush), .i_global_stall(i_global_stall),
    .i_clr_counts(i_clr_counts), .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_retired(o_retired),
    .o_retire_count(o_retire_count), .o_stall_count(o_stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] data;
    logic [N-1:0]   valid;
    logic           ready;
    logic           retired;
    int             rc;
    int             sc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: contents of each stage plus counter values.
  logic [W-1:0] m_data[N];
  bit           m_valid[N];
  int           m_rc, m_sc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A stage is frozen when global stall is up or any stage at or below it stalls.
  function automatic bit frozen(input int k);
    int top;
    top = -1;
    for (int j = 0; j < N; j++) if (i_stall[j]) top = j;
    return i_global_stall || (k <= top);
  endfunction

  function automatic bit model_retired();
    return m_valid[N-1] && !frozen(N-1) && !i_flush[N-1];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_data[k] = '0;
      m_valid[k] = 1'b0;
    end
    m_rc = 0;
    m_sc = 0;
  endtask

  // Apply one clock edge to the model using the inputs held across that edge.
  task automatic model_step();
    logic [W-1:0] nd[N];
    bit           nv[N];
    bit           ret;
    ret = model_retired();
    for (int k = 0; k < N; k++) begin
      if (i_flush[k])            begin nd[k] = '0;          nv[k] = 1'b0;         end
      else if (frozen(k))        begin nd[k] = m_data[k];   nv[k] = m_valid[k];   end
      else if (k == 0)           begin nd[k] = i_data;      nv[k] = i_valid;      end
      else if (frozen(k - 1))    begin nd[k] = '0;          nv[k] = 1'b0;         end
      else                       begin nd[k] = m_data[k-1]; nv[k] = m_valid[k-1]; end
    end
    for (int k = 0; k < N; k++) begin
      m_data[k] = nd[k];
      m_valid[k] = nv[k];
    end
    if (i_clr_counts) begin
      m_rc = 0;
      m_sc = 0;
    end else if (!i_global_stall) begin
      if (ret) m_rc = (m_rc >= MAXC) ? MAXC : m_rc + 1;
      if (i_stall != '0) m_sc = (m_sc >= MAXC) ? MAXC : m_sc + 1;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.data[k*W +: W] = m_data[k];
      e.valid[k] = m_valid[k];
    end
    e.ready = !frozen(0);
    e.retired = model_retired();
    e.rc = m_rc;
    e.sc = m_sc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [W-1:0] d, input logic v, input logic [N-1:0] st,
                       input logic [N-1:0] fl, input logic gs, input logic clr);
    @(posedge clk);
    model_step();
    #1;
    i_data = d; i_valid = v; i_stall = st; i_flush = fl;
    i_global_stall = gs; i_clr_counts = clr;
    push_expect();
  endtask

  // Pulse reset between edges and check the immediate clear, then offer 0x44.
  task automatic mid_reset();
    @(posedge clk);
    model_step();
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_retire_cnt", 64'(o_retire_count), 64'd0);
    check("rst_stall_cnt", 64'(o_stall_count), 64'd0);
    #1 rst = 1'b0;
    model_clear();
    i_data = 8'h44; i_valid = 1'b1; i_stall = '0; i_flush = '0;
    i_global_stall = 1'b0; i_clr_counts = 1'b0;
    push_expect();
  endtask

  // Monitor: compare every DUT observation against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("o_data", 64'(o_data), 64'(e.data));
        check("o_valid", 64'(o_valid), 64'(e.valid));
        check("o_ready", 64'(o_ready), 64'(e.ready));
        check("o_retired", 64'(o_retired), 64'(e.retired));
        check("retire_count", 64'(o_retire_count), 64'(e.rc));
        check("stall_count", 64'(o_stall_count), 64'(e.sc));
      end
    end
  end

  initial begin
    model_clear();
    #2;
    check("init_valid", 64'(o_valid), 64'd0);
    check("init_data", 64'(o_data), 64'd0);
    #10 rst = 1'b0;

    // Reset mid-stream.
    drive(8'h11, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'h22, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'h33, 1, 4'b0000, 4'b0000, 0, 0);
    mid_reset();
    drive(8'h00, 0, 4'b0000, 4'b0000, 0, 0);
    drive(8'h00, 0, 4'b0000, 4'b0000, 0, 0);

    // Straight flow after a counter clear.
    drive(8'h00, 0, 4'b0000, 4'b0000, 0, 1);
    for (int i = 1; i <= 6; i++) drive(W'(i), 1, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) drive(8'h00, 0, 4'b0000, 4'b0000, 0, 0);

    // Load-use stall with A..D in flight.
    drive(8'hA0, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'hB0, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'hC0, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'hD0, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'hE0, 1, 4'b0001, 4'b0000, 0, 0);
    drive(8'hE0, 1, 4'b0000, 4'b0000, 0, 0);

    // Deep stall for two cycles.
    drive(8'hE1, 1, 4'b0100, 4'b0000, 0, 0);
    drive(8'hE1, 1, 4'b0100, 4'b0000, 0, 0);
    drive(8'hE2, 1, 4'b0000, 4'b0000, 0, 0);

    // Branch flush combined with stall on stage 0.
    drive(8'hF0, 1, 4'b0001, 4'b0001, 0, 0);
    drive(8'hF1, 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'hF2, 1, 4'b0000, 4'b0010, 0, 0);

    // Saturation: more than 15 retires, then clear while retiring.
    for (int i = 0; i < 22; i++) drive(W'(8'h80 + i), 1, 4'b0000, 4'b0000, 0, 0);
    drive(8'h55, 1, 4'b0000, 4'b0000, 0, 1);
    drive(8'h56, 1, 4'b0000, 4'b0000, 0, 0);

    // Global stall for three cycles, flushing stage 3 on the second.
    drive(8'h60, 1, 4'b0010, 4'b0000, 1, 0);
    drive(8'h61, 1, 4'b0000, 4'b1000, 1, 0);
    drive(8'h62, 1, 4'b0000, 4'b0000, 1, 0);
    drive(8'h63, 1, 4'b0000, 4'b0000, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] st, fl;
      st = '0;
      fl = '0;
      for (int k = 0; k < N; k++) begin
        st[k] = ($urandom_range(0, 9) == 0);
        fl[k] = ($urandom_range(0, 11) == 0);
      end
      drive(W'($urandom), 1'($urandom_range(0, 3) != 0), st, fl,
            ($urandom_range(0, 14) == 0), ($urandom_range(0, 39) == 0));
    end

    // Reset again with counters and pipeline busy.
    mid_reset();
    drive(8'h00, 0, 4'b0000, 4'b0000, 0, 0);
    drive(8'h00, 0, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
